// File: rtl/stack_pkg.sv
// Shared constants for the synchronous stack and its unloader: default
// widths, the counter-width derivation and the unloader FSM encoding.
package stack_pkg;

  localparam int STK_DW    = 5;
  localparam int STK_DEPTH = 4;

  // len/rem must hold 0..2**depth inclusive, hence one extra bit.
  function automatic int stk_cw(input int depth);
    return depth + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } unl_state_e;

endpackage

// File: rtl/stack_unloader_outreg.sv
// One-entry output register for the unloader's valid/ready port.
// A load overwrites the entry (the caller only loads when it is empty or
// being handed off); otherwise the entry holds until accepted.
// Optional: STACK_UNLOADER_PARITY_EN adds an even-parity bit stored with the word.
module stack_unloader_outreg
  import stack_pkg::*;
#(
  parameter int DW = STK_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o
`ifdef STACK_UNLOADER_PARITY_EN
  , output logic        parity_o
`endif
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;

  // Next entry: load wins, a handshake empties, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

`ifdef STACK_UNLOADER_PARITY_EN
  logic parity_q;

  // Parity is captured alongside the word so it always matches data_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load_i) begin
      parity_q <= ^data_i;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: rtl/stack_unloader.sv
// Pops up to len words from the synchronous stack (newest first) and
// streams them on a valid/ready port. len=0 drains until the stack is empty.
// Optional: STACK_UNLOADER_PARITY_EN adds m_parity_o (even parity of m_data_o).
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | popping words while the output register can take them
// FLUSH | no more pops; waiting for the held word to be accepted
// DONE  | one-cycle completion pulse
module stack_unloader
  import stack_pkg::*;
#(
  parameter int DW    = STK_DW,
  parameter int DEPTH = STK_DEPTH,
  parameter int CW    = stk_cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [CW-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          underrun_o,
  input  logic          stk_empty_i,
  input  logic [DW-1:0] stk_dout_i,
  output logic          stk_pop_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o
`ifdef STACK_UNLOADER_PARITY_EN
  , output logic        m_parity_o
`endif
);

  unl_state_e    state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          drain_q, drain_d;
  logic          underrun_q, underrun_d;
  logic          pop_raw;
  logic          load_last;
  logic          out_valid;
  logic          out_last;

  // Next-state, rem counter and pop decision.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    drain_d    = drain_q;
    underrun_d = underrun_q;
    pop_raw    = 1'b0;
    load_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_RUN;
          rem_d      = len_i;
          drain_d    = (len_i == '0);
          underrun_d = 1'b0;
        end
      end
      ST_RUN: begin
        pop_raw = !stk_empty_i && (drain_q || rem_q != '0) && (!out_valid || m_ready_i);
        if (pop_raw) begin
          if (!drain_q) begin
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              load_last = 1'b1;
              state_d   = ST_FLUSH;
            end
          end
        end else if (stk_empty_i || (!drain_q && rem_q == '0)) begin
          state_d = ST_FLUSH;
          if (!drain_q && rem_q != '0) begin
            underrun_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (!out_valid || m_ready_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      drain_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      underrun_q <= underrun_d;
    end
  end

  // The stack pointer moves on the same edge, so the strobe is masked during reset.
  assign stk_pop_o = pop_raw && !rst;

  stack_unloader_outreg #(
    .DW(DW)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (stk_pop_o),
    .data_i  (stk_dout_i),
    .last_i  (load_last),
    .ready_i (m_ready_i),
    .valid_o (out_valid),
    .data_o  (m_data_o),
    .last_o  (out_last)
`ifdef STACK_UNLOADER_PARITY_EN
    , .parity_o(m_parity_o)
`endif
  );

  assign m_valid_o  = out_valid;
  assign busy_o     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done_o     = (state_q == ST_DONE);
  assign underrun_o = underrun_q;

  // Without an occupancy hint the final drain word is only known once no
  // further pop can happen: in FLUSH, or in RUN with the stack already empty
  // (pushes are excluded while busy). The RUN case keeps m_last on a word
  // that is accepted before the FSM reaches FLUSH.
  assign m_last_o = out_valid &&
                    (out_last || (state_q == ST_FLUSH) ||
                     (state_q == ST_RUN && stk_empty_i));

endmodule

// File: tb/tb_stack_unloader.sv
// Bench for stack_unloader: table-driven bursts, randomized bursts checked
// against a list-level model of the stack, and hand-written reset cases.
// Optional: STACK_UNLOADER_PARITY_EN enables checks on m_parity.
module tb_stack_unloader;

  localparam int DW  = 5;
  localparam int CW  = 5;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len;
  logic          busy, done, underrun;
  logic          stk_empty;
  logic [DW-1:0] stk_dout;
  logic          stk_pop;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef STACK_UNLOADER_PARITY_EN
  logic          m_parity;
`endif

  always #5 clk = ~clk;

  stack_unloader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .underrun_o (underrun),
    .stk_empty_i(stk_empty),
    .stk_dout_i (stk_dout),
    .stk_pop_o  (stk_pop),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last)
`ifdef STACK_UNLOADER_PARITY_EN
    , .m_parity_o(m_parity)
`endif
  );

  // Stack model: mem[sp-1] is the top; pointer moves on the pop edge.
  logic [DW-1:0] mem [CAP];
  logic [DW-1:0] load_mem [CAP];
  int            sp;
  int            load_n;
  logic          load_en;

  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < CAP; k++) mem[k] <= load_mem[k];
      sp <= load_n;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  always_comb begin
    stk_dout = '0;
    if (sp > 0) stk_dout = mem[sp-1];
  end
  assign stk_empty = (sp == 0);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int            n;
    logic [CW-1:0] len;
    int            rmode;
    bit            poke;
    int            beats;
    bit            under;
    int            left;
  } vec_t;

  vec_t tbl [10];

  // Runs one burst from IDLE on the stack currently in load_mem[0..n-1].
  task automatic run_burst(input int n, input logic [CW-1:0] len_v, input int rmode,
                           input bit poke, output int nbeats, output bit und, output int left);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int cnt, cyc, first_valid;
    bit finished, exp_under, prev_valid, prev_ready;
    logic [DW-1:0] prev_data;

    if (len_v == '0) cnt = n;
    else cnt = (int'(len_v) < n) ? int'(len_v) : n;
    exp_under = (len_v != '0) && (int'(len_v) > n);
    for (int k = 0; k < cnt; k++) exp_q.push_back(load_mem[n-1-k]);

    load_n = n; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    start = 1'b1; len = len_v; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; first_valid = -1; finished = 0; prev_valid = 0; prev_ready = 0; prev_data = '0;
    while (!finished && cyc < 200) begin
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = cyc[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = (poke && cyc == 3);
      #1;
      if (cyc == 1) chk("underrun_cleared", underrun, 0);
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
`ifdef STACK_UNLOADER_PARITY_EN
      if (m_valid) chk("parity", m_parity, ^m_data);
`endif
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      if (done) finished = 1;
      prev_valid = m_valid; prev_ready = m_ready; prev_data = m_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; m_ready = 1'b0;
    if (!finished) chk("done_timeout", 0, 1);
    #1;
    chk("done_pulse_width", done, 0);
    chk("underrun", underrun, exp_under);
    chk("stack_left", sp, n - cnt);
    chk("first_valid_cycle", first_valid, (cnt > 0) ? 2 : -1);
    chk("beat_count", got_d.size(), cnt);
    for (int k = 0; k < got_d.size() && k < cnt; k++) begin
      chk("beat_data", got_d[k], exp_q[k]);
      chk("beat_last", got_l[k], (k == cnt - 1));
    end
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    nbeats = got_d.size(); und = underrun; left = sp;
  endtask

  initial begin
    int nb, lf, n;
    bit un;
    logic [CW-1:0] lv;

    rst = 1'b1; start = 1'b1; len = 5'd3; m_ready = 1'b1;
    load_mem[0] = 5'd1; load_mem[1] = 5'd2; load_n = 2; load_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      load_en = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_pop", stk_pop, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_last", m_last, 0);
`ifdef STACK_UNLOADER_PARITY_EN
      chk("rst_parity", m_parity, 0);
`endif
    end
    rst = 1'b0; start = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("rst_no_pop_sp", sp, 2);

    tbl[0] = '{3,  5'd2,  0, 1'b0, 2,  1'b0, 1};
    tbl[1] = '{5,  5'd0,  1, 1'b1, 5,  1'b0, 0};
    tbl[2] = '{2,  5'd4,  0, 1'b0, 2,  1'b1, 0};
    tbl[3] = '{4,  5'd3,  1, 1'b0, 3,  1'b0, 1};
    tbl[4] = '{0,  5'd0,  0, 1'b0, 0,  1'b0, 0};
    tbl[5] = '{0,  5'd3,  0, 1'b1, 0,  1'b1, 0};
    tbl[6] = '{16, 5'd20, 2, 1'b0, 16, 1'b1, 0};
    tbl[7] = '{6,  5'd6,  2, 1'b1, 6,  1'b0, 0};
    tbl[8] = '{16, 5'd0,  2, 1'b0, 16, 1'b0, 0};
    tbl[9] = '{5,  5'd1,  0, 1'b0, 1,  1'b0, 4};

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < CAP; k++) load_mem[k] = DW'((5 * k + 11 + i) % 32);
      if (i == 0) begin
        load_mem[0] = 5'd3; load_mem[1] = 5'd7; load_mem[2] = 5'd9;
      end
      if (i == 1) load_mem[2] = 5'b10110;
      run_burst(tbl[i].n, tbl[i].len, tbl[i].rmode, tbl[i].poke, nb, un, lf);
      chk("tbl_beats", nb, tbl[i].beats);
      chk("tbl_underrun", un, tbl[i].under);
      chk("tbl_left", lf, tbl[i].left);
    end

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, CAP);
      lv = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 20));
      for (int k = 0; k < CAP; k++) load_mem[k] = DW'($urandom_range(0, 31));
      run_burst(n, lv, 2, 1'($urandom_range(0, 1)), nb, un, lf);
    end

    // Reset in the middle of a stalled burst drops the held word.
    for (int k = 0; k < CAP; k++) load_mem[k] = DW'(k + 1);
    load_n = 4; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b1; len = '0; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_valid_before_rst", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_pop_in_rst", stk_pop, 0);
    @(negedge clk);
    chk("mid_valid", m_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pop", stk_pop, 0);
    chk("mid_data", m_data, 0);
    chk("mid_sp", sp, 3);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
